// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I decode/control stage: opcode constants,
// ALU operation classes, branch/jump codes and the control bundle layout.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    localparam logic [2:0] ALU_OP_ADD    = 3'b000;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
    localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;
    localparam logic [2:0] ALU_OP_LUI    = 3'b100;
    localparam logic [2:0] ALU_OP_AUIPC  = 3'b101;
    localparam logic [2:0] ALU_OP_MEXT   = 3'b110;

    localparam logic [1:0] BJ_NONE   = 2'b00;
    localparam logic [1:0] BJ_BRANCH = 2'b01;
    localparam logic [1:0] BJ_JAL    = 2'b10;
    localparam logic [1:0] BJ_JALR   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       alu_data1;
        logic       mem_write;
        logic       mem_read;
        logic       men_to_reg;
        logic [1:0] branch_jump;
    } ctrl_bundle_t;

    // Only R, S and B formats carry a meaningful rs2 field.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode/funct7 -> control bundle decoder.
// Optional feature macro: CONTROL_MEXT_EN (funct7=0000001 R-type -> ALU_OP_MEXT).
module control_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [6:0]   i_funct7,
    output ctrl_bundle_t o_bundle,
    output logic         o_uses_rs2
);

    logic w_is_mext;

`ifdef CONTROL_MEXT_EN
    assign w_is_mext = (i_funct7 == F7_MEXT);
`else
    // funct7 plays no part in decode without M-extension support
    logic w_unused_funct7;
    assign w_unused_funct7 = ^i_funct7;
    assign w_is_mext       = 1'b0;
`endif

    assign o_uses_rs2 = uses_rs2(i_opcode);

    // Opcode table; unknown opcodes fall through as an all-zero NOP bundle.
    always_comb begin
        o_bundle = '0;
        case (i_opcode)
            OP_R: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_op    = w_is_mext ? ALU_OP_MEXT : ALU_OP_RTYPE;
            end
            OP_I: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_op    = ALU_OP_ITYPE;
                o_bundle.alu_src   = 1'b1;
            end
            OP_LOAD: begin
                o_bundle.reg_write  = 1'b1;
                o_bundle.alu_op     = ALU_OP_ADD;
                o_bundle.alu_src    = 1'b1;
                o_bundle.mem_read   = 1'b1;
                o_bundle.men_to_reg = 1'b1;
            end
            OP_STORE: begin
                o_bundle.alu_op     = ALU_OP_ADD;
                o_bundle.alu_src    = 1'b1;
                o_bundle.mem_write  = 1'b1;
                o_bundle.men_to_reg = 1'b1;
            end
            OP_BRANCH: begin
                o_bundle.alu_op      = ALU_OP_BRANCH;
                o_bundle.men_to_reg  = 1'b1;
                o_bundle.branch_jump = BJ_BRANCH;
            end
            OP_LUI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_op    = ALU_OP_LUI;
                o_bundle.alu_src   = 1'b1;
            end
            OP_AUIPC: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_op    = ALU_OP_AUIPC;
                o_bundle.alu_src   = 1'b1;
                o_bundle.alu_data1 = 1'b1;
            end
            OP_JAL: begin
                o_bundle.reg_write   = 1'b1;
                o_bundle.alu_op      = ALU_OP_ADD;
                o_bundle.branch_jump = BJ_JAL;
            end
            OP_JALR: begin
                o_bundle.reg_write   = 1'b1;
                o_bundle.alu_op      = ALU_OP_ITYPE;
                o_bundle.alu_src     = 1'b1;
                o_bundle.branch_jump = BJ_JALR;
            end
            default: o_bundle = '0;
        endcase
    end

endmodule

// File: rtl/control_stage.sv
// Registered RV32I decode/control stage: valid/ready output register,
// load-use tracker with LOAD_BUBBLES bubble insertion, flush, bubble counter.
// Optional feature macro: CONTROL_MEXT_EN (handled in control_decode).
module control_stage
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int STAT_W       = 16
)(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [6:0]            opcode_i,
    input  logic [6:0]            funct7_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  reg_write_o,
    output logic                  alu_src_o,
    output logic                  alu_data1_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic                  men_to_reg_o,
    output logic [2:0]            alu_op_o,
    output logic [1:0]            branch_jump_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [STAT_W-1:0]     bubble_cnt_o
);

    localparam int STALL_W = $clog2(LOAD_BUBBLES + 1);

    ctrl_bundle_t          r_bundle, w_bundle_next, w_dec;
    logic                  r_out_valid, w_out_valid_next;
    logic [REG_ADDR_W-1:0] r_rd, w_rd_next;
    logic [STALL_W-1:0]    r_stall_cnt, w_stall_next;
    logic                  r_trk_is_load, w_trk_is_load_next;
    logic [REG_ADDR_W-1:0] r_trk_rd, w_trk_rd_next;
    logic [STAT_W-1:0]     r_bubble_cnt, w_bubble_next;
    logic                  w_uses_rs2, w_slot_free, w_hazard, w_in_ready, w_accept;

    control_decode u_decode (
        .i_opcode   (opcode_i),
        .i_funct7   (funct7_i),
        .o_bundle   (w_dec),
        .o_uses_rs2 (w_uses_rs2)
    );

    assign w_slot_free = !r_out_valid || out_ready_i;
    assign w_hazard    = in_valid_i && r_trk_is_load && (r_trk_rd != '0) &&
                         ((rs1_i == r_trk_rd) || (w_uses_rs2 && (rs2_i == r_trk_rd)));
    assign w_in_ready  = !flush_i && w_slot_free && (r_stall_cnt == '0) && !w_hazard;
    assign w_accept    = in_valid_i && w_in_ready;

    // Next-state: flush wins; otherwise accept/drain the output slot and run the stall counter.
    always_comb begin
        w_out_valid_next   = r_out_valid;
        w_bundle_next      = r_bundle;
        w_rd_next          = r_rd;
        w_stall_next       = r_stall_cnt;
        w_trk_is_load_next = r_trk_is_load;
        w_trk_rd_next      = r_trk_rd;
        w_bubble_next      = r_bubble_cnt;
        if (flush_i) begin
            w_out_valid_next   = 1'b0;
            w_stall_next       = '0;
            w_trk_is_load_next = 1'b0;
            w_trk_rd_next      = '0;
        end else begin
            if (w_accept) begin
                w_out_valid_next   = 1'b1;
                w_bundle_next      = w_dec;
                w_rd_next          = rd_i;
                w_trk_is_load_next = w_dec.mem_read;
                w_trk_rd_next      = rd_i;
            end else if (w_slot_free) begin
                w_out_valid_next = 1'b0;
            end
            if (r_stall_cnt != '0) begin
                // A bubble only counts once EX has room to see it.
                if (w_slot_free) begin
                    w_stall_next = r_stall_cnt - STALL_W'(1);
                    if (r_bubble_cnt != '1) begin
                        w_bubble_next = r_bubble_cnt + STAT_W'(1);
                    end
                    if (r_stall_cnt == STALL_W'(1)) begin
                        w_trk_is_load_next = 1'b0;
                    end
                end
            end else if (w_hazard) begin
                w_stall_next = STALL_W'(LOAD_BUBBLES);
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid   <= 1'b0;
            r_bundle      <= '0;
            r_rd          <= '0;
            r_stall_cnt   <= '0;
            r_trk_is_load <= 1'b0;
            r_trk_rd      <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            r_out_valid   <= w_out_valid_next;
            r_bundle      <= w_bundle_next;
            r_rd          <= w_rd_next;
            r_stall_cnt   <= w_stall_next;
            r_trk_is_load <= w_trk_is_load_next;
            r_trk_rd      <= w_trk_rd_next;
            r_bubble_cnt  <= w_bubble_next;
        end
    end

    assign in_ready_o    = w_in_ready;
    assign out_valid_o   = r_out_valid;
    assign reg_write_o   = r_bundle.reg_write;
    assign alu_op_o      = r_bundle.alu_op;
    assign alu_src_o     = r_bundle.alu_src;
    assign alu_data1_o   = r_bundle.alu_data1;
    assign mem_write_o   = r_bundle.mem_write;
    assign mem_read_o    = r_bundle.mem_read;
    assign men_to_reg_o  = r_bundle.men_to_reg;
    assign branch_jump_o = r_bundle.branch_jump;
    assign rd_o          = r_rd;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule
